alu_wb_stage: RTL and testbench

Writeback stage directly downstream of the ALU op units (op_xor and siblings). It accepts one ALU result per handshake and updates the APSR flag register (N, Z, C, V) in program order. It buffers pending register writes in a small FIFO that drains to the register-file write port and the PC-load path. Its APSR outputs are the `carry_in`/`zero_in`/`neg_in` sources for the ALU ops, and a lookup port lets decode forward results that have not yet retired.

---
 rtl/alu_wb_stage_pkg.sv | 18 +
 rtl/alu_wb_stage_wb_fifo.sv | 71 +++++++
 rtl/alu_wb_stage.sv | 102 ++++++++++
 tb/tb_alu_wb_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_wb_stage_pkg.sv
// Shared constants and types for the ALU writeback stage.
// Pulled in by the stage top and its pending-write FIFO.
package alu_wb_stage_pkg;

    localparam logic [3:0] PC_REG = 4'd15;
    localparam int ENTRY_W = 36;

    localparam int APSR_N = 3;
    localparam int APSR_Z = 2;
    localparam int APSR_C = 1;
    localparam int APSR_V = 0;

    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/alu_wb_stage_wb_fifo.sv
// Pending register-write FIFO with youngest-match forwarding lookup.
// Storage is not reset; only entries inside count are ever observed.
module wb_fifo
    import alu_wb_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  wb_entry_t              push_entry,
    input  logic                   pop,
    output wb_entry_t              head,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] count_nxt,
    input  logic [3:0]             lk_addr,
    output logic                   lk_hit,
    output logic [31:0]            lk_data
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] idx;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_entry;
    end

    assign head = mem[rd_ptr];

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        idx     = rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (k < int'(count) && mem[idx].rd == lk_addr) begin
                lk_hit  = 1'b1;
                lk_data = mem[idx].data;
            end
        end
    end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: APSR update, retire counter, and drain of
// buffered register/PC writes with a forwarding lookup port.
module alu_wb_stage
    import alu_wb_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_rd,
    input  logic [31:0] in_result,
    input  logic        in_wr,
    input  logic        in_s,
    input  logic        in_n,
    input  logic        in_z,
    input  logic        in_c,
    input  logic        in_v,
    output logic        apsr_n,
    output logic        apsr_z,
    output logic        apsr_c,
    output logic        apsr_v,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic        rf_ack,
    output logic        pc_load,
    output logic [31:0] pc_target,
    input  logic [3:0]  lk_addr,
    output logic        lk_hit,
    output logic [31:0] lk_data,
    output logic [31:0] retired
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             ready_q;
    logic             accept;
    logic             push;
    logic             pop;
    logic             head_valid;
    logic             head_pc;
    logic [3:0]       apsr_q;
    logic [31:0]      retired_q;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    wb_entry_t        head;
    wb_entry_t        push_entry;

    assign accept     = in_valid & ready_q;
    assign push       = accept & in_wr;
    assign push_entry = '{rd: in_rd, data: in_result};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .count_nxt  (count_nxt),
        .lk_addr    (lk_addr),
        .lk_hit     (lk_hit),
        .lk_data    (lk_data)
    );

    assign head_valid = count != '0;
    assign head_pc    = head.rd == PC_REG;
    assign rf_we      = head_valid & ~head_pc;
    assign pc_load    = head_valid & head_pc;
    // PC writes retire by themselves; rf_ack only matters for rf writes.
    assign pop        = (rf_we & rf_ack) | pc_load;

    assign rf_waddr  = head.rd;
    assign rf_wdata  = head.data;
    assign pc_target = {head.data[31:1], 1'b0};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q   <= 1'b0;
            apsr_q    <= '0;
            retired_q <= '0;
        end else begin
            ready_q <= count_nxt < CNT_W'(DEPTH);
            if (accept) begin
                retired_q <= retired_q + 32'd1;
                if (in_s)
                    apsr_q <= {in_n, in_z, in_c, in_v};
            end
        end
    end

    assign in_ready = ready_q;
    assign retired  = retired_q;
    assign apsr_n   = apsr_q[APSR_N];
    assign apsr_z   = apsr_q[APSR_Z];
    assign apsr_c   = apsr_q[APSR_C];
    assign apsr_v   = apsr_q[APSR_V];

endmodule

// File: tb/tb_alu_wb_stage.sv
// Scoreboard bench for alu_wb_stage: queue model of pending writes,
// directed scenarios followed by randomized traffic.
module tb_alu_wb_stage;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_rd = '0;
    logic [31:0] in_result = '0;
    logic        in_wr = 1'b0;
    logic        in_s = 1'b0;
    logic        in_n = 1'b0;
    logic        in_z = 1'b0;
    logic        in_c = 1'b0;
    logic        in_v = 1'b0;
    logic        apsr_n, apsr_z, apsr_c, apsr_v;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_ack = 1'b0;
    logic        pc_load;
    logic [31:0] pc_target;
    logic [3:0]  lk_addr = '0;
    logic        lk_hit;
    logic [31:0] lk_data;
    logic [31:0] retired;

    alu_wb_stage #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rd     (in_rd),
        .in_result (in_result),
        .in_wr     (in_wr),
        .in_s      (in_s),
        .in_n      (in_n),
        .in_z      (in_z),
        .in_c      (in_c),
        .in_v      (in_v),
        .apsr_n    (apsr_n),
        .apsr_z    (apsr_z),
        .apsr_c    (apsr_c),
        .apsr_v    (apsr_v),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_ack    (rf_ack),
        .pc_load   (pc_load),
        .pc_target (pc_target),
        .lk_addr   (lk_addr),
        .lk_hit    (lk_hit),
        .lk_data   (lk_data),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic        chk_en = 1'b0;
    ent_t        q[$];
    logic [3:0]  apsr_m = '0;
    logic [31:0] ret_m = '0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; the model advances at the edge that accepts.
    task automatic drive(input logic v, input logic [3:0] rd,
                         input logic [31:0] d, input logic wr,
                         input logic s, input logic [3:0] nzcv,
                         input logic ack, input logic [3:0] lk);
        logic rdy;
        in_valid  = v;
        in_rd     = rd;
        in_result = d;
        in_wr     = wr;
        in_s      = s;
        {in_n, in_z, in_c, in_v} = nzcv;
        rf_ack    = ack;
        lk_addr   = lk;
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk);
        if (v && rdy) begin
            ret_m = ret_m + 32'd1;
            if (s)
                apsr_m = nzcv;
            if (wr)
                q.push_back('{rd: rd, d: d});
        end
        #1;
    endtask

    task automatic idle(input logic ack, input logic [3:0] lk);
        drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, ack, lk);
    endtask

    ent_t        h;
    logic        exp_we, exp_pc, exp_hit;
    logic [31:0] exp_lk;

    always @(negedge clk) begin
        if (chk_en) begin
            exp_we = 1'b0;
            exp_pc = 1'b0;
            if (q.size() > 0) begin
                h = q[0];
                exp_pc = h.rd == 4'd15;
                exp_we = !exp_pc;
            end
            check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
            check("apsr", 32'({apsr_n, apsr_z, apsr_c, apsr_v}), 32'(apsr_m));
            check("retired", retired, ret_m);
            check("rf_we", 32'(rf_we), 32'(exp_we));
            check("pc_load", 32'(pc_load), 32'(exp_pc));
            if (exp_we) begin
                check("rf_waddr", 32'(rf_waddr), 32'(h.rd));
                check("rf_wdata", rf_wdata, h.d);
            end
            if (exp_pc)
                check("pc_target", pc_target, h.d & 32'hFFFF_FFFE);
            exp_hit = 1'b0;
            exp_lk  = '0;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (!exp_hit && q[i].rd == lk_addr) begin
                    exp_hit = 1'b1;
                    exp_lk  = q[i].d;
                end
            end
            check("lk_hit", 32'(lk_hit), 32'(exp_hit));
            check("lk_data", lk_data, exp_lk);
            if (exp_pc || (exp_we && rf_ack))
                void'(q.pop_front());
        end
    end

    initial begin
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_retired", retired, 32'd0);
        #10 rst = 1'b1;
        @(posedge clk);
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
        chk_en = 1'b1;

        drive(1'b1, 4'd7, 32'hDEAD, 1'b0, 1'b1, 4'b1010, 1'b1, 4'd7);
        check("flags_apsr", 32'({apsr_n, apsr_z, apsr_c, apsr_v}), 32'hA);
        check("flags_retired", retired, 32'd1);
        check("flags_no_we", 32'(rf_we), 32'd0);
        idle(1'b1, 4'd7);

        drive(1'b1, 4'd3, 32'hA, 1'b1, 1'b0, 4'd0, 1'b0, 4'd3);
        drive(1'b1, 4'd4, 32'hB, 1'b1, 1'b0, 4'd0, 1'b0, 4'd4);
        check("full_ready", 32'(in_ready), 32'd0);
        check("full_waddr", 32'(rf_waddr), 32'd3);
        drive(1'b1, 4'd9, 32'hC, 1'b1, 1'b0, 4'd0, 1'b0, 4'd9);
        check("hold_waddr", 32'(rf_waddr), 32'd3);
        idle(1'b1, 4'd0);
        check("pop_ready", 32'(in_ready), 32'd1);
        check("pop_waddr", 32'(rf_waddr), 32'd4);
        idle(1'b1, 4'd0);

        drive(1'b1, 4'd15, 32'h0000_1235, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        check("pc_load_hi", 32'(pc_load), 32'd1);
        check("pc_target", pc_target, 32'h0000_1234);
        idle(1'b0, 4'd0);
        check("pc_load_lo", 32'(pc_load), 32'd0);
        check("pc_empty_we", 32'(rf_we), 32'd0);

        drive(1'b1, 4'd5, 32'h1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd5);
        drive(1'b1, 4'd5, 32'h2, 1'b1, 1'b0, 4'd0, 1'b0, 4'd5);
        check("fwd_hit", 32'(lk_hit), 32'd1);
        check("fwd_data", lk_data, 32'h2);
        lk_addr = 4'd6;
        #1;
        check("fwd_miss", 32'(lk_hit), 32'd0);
        idle(1'b1, 4'd6);
        idle(1'b1, 4'd5);

        drive(1'b1, 4'd1, 32'h11, 1'b1, 1'b0, 4'd0, 1'b0, 4'd1);
        drive(1'b1, 4'd2, 32'h22, 1'b1, 1'b0, 4'd0, 1'b0, 4'd1);
        chk_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("mid_rf_we", 32'(rf_we), 32'd0);
        check("mid_lk_hit", 32'(lk_hit), 32'd0);
        check("mid_apsr", 32'({apsr_n, apsr_z, apsr_c, apsr_v}), 32'd0);
        check("mid_retired", retired, 32'd0);
        check("mid_ready", 32'(in_ready), 32'd0);
        q.delete();
        apsr_m = '0;
        ret_m  = '0;
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rel_ready", 32'(in_ready), 32'd1);
        chk_en = 1'b1;

        for (int i = 0; i < 10; i++)
            drive(1'b1, 4'(i), 32'h100 + 32'(i), 1'b1, 1'b0, 4'd0, 1'b1, 4'(i));
        check("stream_retired", retired, 32'd10);
        idle(1'b1, 4'd0);

        #1 force dut.retired_q = 32'hFFFF_FFFF;
        ret_m = 32'hFFFF_FFFF;
        #1 release dut.retired_q;
        drive(1'b1, 4'd8, 32'h8, 1'b0, 1'b0, 4'd0, 1'b1, 4'd0);
        check("wrap_retired", retired, 32'd0);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7,
                  4'($urandom_range(0, 15)),
                  $urandom,
                  $urandom_range(0, 9) < 7,
                  1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)),
                  $urandom_range(0, 9) < 6,
                  4'($urandom_range(0, 15)));
        end
        for (int i = 0; i < 4; i++)
            idle(1'b1, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
